// File: rtl/lock_ctrl_pkg.sv
// Shared types and helpers for the locked-register unlock controller.
//   lock_state_e : controller state encoding
//   KEY*_DEFAULT : default unlock key words
//   cnt_width()  : bit width of a counter/index over n values (minimum 1)
package lock_ctrl_pkg;

    typedef enum logic [1:0] {
        LOCKED    = 2'd0,
        KEY1_WAIT = 2'd1,
        UNLOCKED  = 2'd2,
        LOCKOUT   = 2'd3
    } lock_state_e;

    localparam logic [7:0] KEY0_DEFAULT = 8'hA5;
    localparam logic [7:0] KEY1_DEFAULT = 8'h5A;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/locked_reg_unlock_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Ports:
//   clk, resetn  : clock, async active-low reset
//   req          : request vector
//   advance      : move the pointer past the winner when a grant is made
//   grant        : one-hot grant (combinational)
//   grant_idx    : index of the granted requester (combinational)
module rr_arbiter
    import lock_ctrl_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;

    // Priority search rotated to start at the pointer.
    always_comb begin : search
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_q) + i) % N);
            if (req[idx] && !found) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer moves to winner+1 (mod N) on every grant.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/locked_reg_unlock_ctrl.sv
// Gatekeeper for a bank of lock-protected registers. A two-key sequence
// (KEY0 then KEY1) opens a bounded write window; requesters are arbitrated
// round-robin onto the single reg_en/reg_d write path. Repeated bad keys
// lead to a sticky lockout that only reset clears.
// Build option: define UNLOCK_EXTEND_EN to make every honoured write
// reload the window counter (sliding window); default is a fixed window.
// Ports:
//   clk, resetn          : clock, async active-low reset
//   key_valid, key_data  : unlock key word and qualifier
//   relock               : force relock
//   req_valid/addr/data  : packed per-requester write requests
//   req_ready            : one-hot grant (combinational)
//   reg_en, reg_d        : registered enable/data to the locked registers
//   unlocked, lockout    : registered state indicators
//   wr_err               : one-cycle pulse for an accepted but rejected write
module locked_reg_unlock_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter  int unsigned   N_REQ    = 2,
    parameter  int unsigned   N_REGS   = 4,
    parameter  int unsigned   DW       = 8,
    parameter  logic [DW-1:0] KEY0     = DW'(KEY0_DEFAULT),
    parameter  logic [DW-1:0] KEY1     = DW'(KEY1_DEFAULT),
    parameter  int unsigned   WINDOW   = 16,
    parameter  int unsigned   MAX_FAIL = 3,
    localparam int unsigned   AW       = cnt_width(N_REGS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                key_valid,
    input  logic [DW-1:0]       key_data,
    input  logic                relock,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REGS-1:0]   reg_en,
    output logic [DW-1:0]       reg_d,
    output logic                unlocked,
    output logic                lockout,
    output logic                wr_err
);

    localparam int unsigned   CW      = cnt_width(WINDOW);
    localparam int unsigned   FW      = cnt_width(MAX_FAIL + 1);
    localparam int unsigned   IW      = cnt_width(N_REQ);
    localparam logic [CW-1:0] WIN_MAX = CW'(WINDOW - 1);

    lock_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [N_REGS-1:0] reg_en_q, reg_en_d;
    logic [DW-1:0]   reg_d_q, reg_d_d;
    logic            wr_err_q, wr_err_d;
    logic            unlocked_q, unlocked_d;
    logic            lockout_q, lockout_d;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic [AW-1:0]    addr_sel;
    logic [DW-1:0]    data_sel;
    logic             accept;
    logic             addr_ok;
    logic             honour;
    logic             key_fail;

    // Arbitration runs in every state so requesters always complete.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req_valid),
        .advance   (1'b1),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign addr_sel  = req_addr[32'(grant_idx) * AW +: AW];
    assign data_sel  = req_data[32'(grant_idx) * DW +: DW];
    assign accept    = |grant;
    assign addr_ok   = (32'(addr_sel) < N_REGS);
    assign honour    = accept && (state_q == UNLOCKED) && !relock && addr_ok;

    // Write path: honoured writes pulse reg_en next cycle, rejected ones pulse wr_err.
    always_comb begin
        reg_en_d = '0;
        reg_d_d  = reg_d_q;
        wr_err_d = accept && !honour;
        if (honour) begin
            reg_en_d[addr_sel] = 1'b1;
            reg_d_d            = data_sel;
        end
    end

    // Unlock sequencing, window countdown and failure accounting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        key_fail = 1'b0;
        case (state_q)
            LOCKED: begin
                if (relock) begin
                    state_d = LOCKED;
                end else if (key_valid) begin
                    if (key_data == KEY0) begin
                        state_d = KEY1_WAIT;
                        cnt_d   = WIN_MAX;
                    end else begin
                        key_fail = 1'b1;
                    end
                end
            end
            KEY1_WAIT: begin
                if (relock) begin
                    state_d = LOCKED;
                end else if (key_valid) begin
                    if (key_data == KEY1) begin
                        state_d = UNLOCKED;
                        cnt_d   = WIN_MAX;
                        fail_d  = '0;
                    end else begin
                        key_fail = 1'b1;
                        state_d  = LOCKED;
                    end
                end else if (cnt_q == '0) begin
                    // Timeout is not a failed attempt.
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    state_d = LOCKED;
`ifdef UNLOCK_EXTEND_EN
                end else if (honour) begin
                    // Activity slides the window, even on its last cycle.
                    cnt_d = WIN_MAX;
`endif
                end else if (cnt_q == '0) begin
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LOCKOUT: begin
                state_d = LOCKOUT;
            end
            default: begin
                state_d = LOCKOUT;
            end
        endcase
        if (key_fail) begin
            fail_d = fail_q + FW'(1);
            if (fail_d == FW'(MAX_FAIL)) begin
                state_d = LOCKOUT;
            end
        end
    end

    assign unlocked_d = (state_d == UNLOCKED);
    assign lockout_d  = (state_d == LOCKOUT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LOCKED;
            cnt_q      <= '0;
            fail_q     <= '0;
            reg_en_q   <= '0;
            reg_d_q    <= '0;
            wr_err_q   <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            wr_err_q   <= wr_err_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
        end
    end

    assign reg_en   = reg_en_q;
    assign reg_d    = reg_d_q;
    assign wr_err   = wr_err_q;
    assign unlocked = unlocked_q;
    assign lockout  = lockout_q;

endmodule

// File: tb/tb_locked_reg_unlock_ctrl.sv
// Self-checking bench for locked_reg_unlock_ctrl (default parameters).
// Expected write-path results are queued when a request is driven and
// compared when the registered outputs appear one cycle later.
module tb_locked_reg_unlock_ctrl;

`ifdef UNLOCK_EXTEND_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       key_valid;
    logic [7:0] key_data;
    logic       relock;
    logic [1:0] req_valid;
    logic [3:0] req_addr;
    logic [15:0] req_data;
    logic [1:0] req_ready;
    logic [3:0] reg_en;
    logic [7:0] reg_d;
    logic       unlocked;
    logic       lockout;
    logic       wr_err;

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] d;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] last_d;
    int         n_cmp;
    int         n_bad;

    locked_reg_unlock_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_valid (key_valid),
        .key_data  (key_data),
        .relock    (relock),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_en    (reg_en),
        .reg_d     (reg_d),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .wr_err    (wr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", tag, act, exp);
        end
    endtask

    // One clock of stimulus; open says whether a granted write should be honoured.
    task automatic step(input logic kv, input logic [7:0] kd, input logic rel,
                        input logic [1:0] rv, input logic [1:0] a0, input logic [7:0] d0,
                        input logic [1:0] a1, input logic [7:0] d1,
                        input logic [1:0] exp_rdy, input logic open);
        exp_t       e;
        logic [1:0] a;
        logic [7:0] d;
        key_valid = kv;
        key_data  = kd;
        relock    = rel;
        req_valid = rv;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        e.en  = '0;
        e.d   = last_d;
        e.err = 1'b0;
        if (exp_rdy != 2'b00) begin
            a = exp_rdy[1] ? a1 : a0;
            d = exp_rdy[1] ? d1 : d0;
            if (open) begin
                e.en[a] = 1'b1;
                e.d     = d;
                last_d  = d;
            end else begin
                e.err = 1'b1;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("reg_en", 32'(reg_en), 32'(e.en));
        chk("reg_d",  32'(reg_d),  32'(e.d));
        chk("wr_err", 32'(wr_err), 32'(e.err));
        key_valid = 1'b0;
        relock    = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b0, 2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic key(input logic [7:0] k);
        step(1'b1, k, 1'b0, 2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic wr0(input logic [1:0] a, input logic [7:0] d, input logic open);
        step(1'b0, 8'h00, 1'b0, 2'b01, a, d, 2'd0, 8'h00, 2'b01, open);
    endtask

    task automatic do_relock();
        step(1'b0, 8'h00, 1'b1, 2'b00, 2'd0, 8'h00, 2'd0, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        key_valid = 1'b0;
        relock    = 1'b0;
        req_valid = 2'b00;
        resetn    = 1'b0;
        #1;
        chk("rst_reg_en",   32'(reg_en),   32'h0);
        chk("rst_reg_d",    32'(reg_d),    32'h0);
        chk("rst_wr_err",   32'(wr_err),   32'h0);
        chk("rst_unlocked", 32'(unlocked), 32'h0);
        chk("rst_lockout",  32'(lockout),  32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        last_d = 8'h00;
    endtask

    initial begin
        resetn    = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        relock    = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        n_cmp     = 0;
        n_bad     = 0;
        last_d    = 8'h00;
        #1;
        do_reset();

        // Unlock and single write.
        key(8'hA5);
        chk("unlocked_key0", 32'(unlocked), 32'h0);
        key(8'h5A);
        chk("unlocked_key1", 32'(unlocked), 32'h1);
        wr0(2'd2, 8'h3C, 1'b1);
        idle(1);

        // Both requesters: pointer sits at 1 after requester 0 won.
        for (int i = 0; i < 4; i++)
            step(1'b0, 8'h00, 1'b0, 2'b11, 2'd0, 8'(8'h10 + i), 2'd3, 8'(8'h20 + i),
                 (i % 2 == 0) ? 2'b10 : 2'b01, 1'b1);

        // Relock coincident with a write.
        step(1'b0, 8'h00, 1'b1, 2'b01, 2'd1, 8'h77, 2'd0, 8'h00, 2'b01, 1'b0);
        chk("unlocked_relock", 32'(unlocked), 32'h0);
        step(1'b0, 8'h00, 1'b0, 2'b10, 2'd0, 8'h00, 2'd1, 8'h99, 2'b10, 1'b0);

        // Window expiry after 16 cycles.
        key(8'hA5);
        key(8'h5A);
        idle(15);
        chk("unlocked_c15", 32'(unlocked), 32'h1);
        idle(1);
        chk("unlocked_c16", 32'(unlocked), 32'h0);
        wr0(2'd0, 8'h44, 1'b0);

        // Write on the last window cycle is honoured.
        key(8'hA5);
        key(8'h5A);
        idle(15);
        wr0(2'd3, 8'h66, 1'b1);
        chk("unlocked_lastwr", 32'(unlocked), 32'(EXT));
        do_relock();

        // Mid-window write: extends only with the sliding window.
        key(8'hA5);
        key(8'h5A);
        idle(4);
        wr0(2'd1, 8'h12, 1'b1);
        idle(11);
        chk("unlocked_midwr", 32'(unlocked), 32'(EXT));
        do_relock();

`ifdef UNLOCK_EXTEND_EN
        key(8'hA5);
        key(8'h5A);
        for (int i = 0; i < 5; i++) begin
            wr0(2'd2, 8'(8'h50 + i), 1'b1);
            idle(9);
            chk("unlocked_extend", 32'(unlocked), 32'h1);
        end
        do_relock();
`endif

        // KEY1 accepted on the final wait cycle.
        key(8'hA5);
        idle(15);
        key(8'h5A);
        chk("unlocked_k1_last", 32'(unlocked), 32'h1);
        do_relock();

        // KEY1 wait timeout, then late KEY1 counts as a failure.
        key(8'hA5);
        idle(16);
        key(8'h5A);
        chk("unlocked_late_k1", 32'(unlocked), 32'h0);
        key(8'h11);
        chk("lockout_fail2", 32'(lockout), 32'h0);
        key(8'h33);
        chk("lockout_fail3", 32'(lockout), 32'h1);

        // Lockout is absorbing.
        key(8'hA5);
        key(8'h5A);
        chk("unlocked_in_lockout", 32'(unlocked), 32'h0);
        step(1'b0, 8'h00, 1'b0, 2'b11, 2'd0, 8'hAA, 2'd1, 8'hBB, 2'b10, 1'b0);
        do_relock();
        chk("lockout_sticky", 32'(lockout), 32'h1);
        do_reset();

        // Three bad keys straight from reset.
        key(8'h11);
        key(8'h22);
        chk("lockout_after_2", 32'(lockout), 32'h0);
        key(8'h33);
        chk("lockout_after_3", 32'(lockout), 32'h1);
        do_reset();

        // Async reset mid-window with a write in flight.
        key(8'hA5);
        key(8'h5A);
        req_valid = 2'b01;
        req_addr  = {2'd0, 2'd1};
        req_data  = {8'h00, 8'h55};
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_unlocked", 32'(unlocked), 32'h0);
        chk("mid_rst_en_now", 32'(reg_en), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_en_edge", 32'(reg_en), 32'h0);
        chk("mid_rst_d", 32'(reg_d), 32'h0);
        chk("mid_rst_err", 32'(wr_err), 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        last_d = 8'h00;

        // Pointer back at 0 after reset; locked write is rejected.
        step(1'b0, 8'h00, 1'b0, 2'b11, 2'd2, 8'hC1, 2'd3, 8'hC2, 2'b01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
